// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arbiter_pkg;

  localparam int unsigned NPORTS_DEFAULT = 2;
  localparam logic [3:0]  BE_FULL        = 4'b1111;

  typedef enum logic {
    IDLE,
    RMW_WR
  } state_t;

endpackage

// File: rtl/dmem_be_merge.sv
// Byte-lane merge: lanes selected by be come from new_word, the rest from old_word.
module dmem_be_merge (
  input  logic [31:0] old_word,
  input  logic [31:0] new_word,
  input  logic [3:0]  be,
  output logic [31:0] merged
);

  logic [31:0] lane_mask;

  assign lane_mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  assign merged    = (new_word & lane_mask) | (old_word & ~lane_mask);

endmodule

// File: rtl/dmem_arbiter.sv
// N-port data-memory arbiter: single-cycle loads/full stores, two-cycle
// read-modify-write for partial stores, round-robin or fixed priority.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned NPORTS = NPORTS_DEFAULT,
  parameter bit          RR_EN  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NPORTS-1:0]    req,
  input  logic [NPORTS-1:0]    we,
  input  logic [NPORTS*32-1:0] addr,
  input  logic [NPORTS*32-1:0] wdata,
  input  logic [NPORTS*4-1:0]  be,
  output logic [NPORTS-1:0]    gnt,
  output logic [NPORTS-1:0]    rvalid,
  output logic [31:0]          rdata,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  input  logic [31:0]          mem_rdata
);

  localparam int unsigned IW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  state_t          state, state_nxt;
  logic [IW-1:0]   last_gnt, sel;
  logic            any_gnt;
  logic            sel_we;
  logic [31:0]     sel_addr, sel_wdata;
  logic [3:0]      sel_be;
  logic [31:0]     aligned_addr;
  logic [31:0]     merged;
  logic [31:0]     cap_addr, cap_data;
  logic            load_go, rmw_go;

  // Round-robin as two passes: ports above last_gnt first, then wrap from port 0.
  always_comb begin
    gnt       = '0;
    sel       = '0;
    any_gnt   = 1'b0;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_be    = '0;
    if (rst_n && state == IDLE) begin
      if (RR_EN) begin
        for (int unsigned i = 0; i < NPORTS; i++) begin
          if (!any_gnt && req[i] && IW'(i) > last_gnt) begin
            any_gnt   = 1'b1;
            sel       = IW'(i);
            gnt[i]    = 1'b1;
            sel_we    = we[i];
            sel_addr  = addr[i*32 +: 32];
            sel_wdata = wdata[i*32 +: 32];
            sel_be    = be[i*4 +: 4];
          end
        end
      end
      for (int unsigned i = 0; i < NPORTS; i++) begin
        if (!any_gnt && req[i]) begin
          any_gnt   = 1'b1;
          sel       = IW'(i);
          gnt[i]    = 1'b1;
          sel_we    = we[i];
          sel_addr  = addr[i*32 +: 32];
          sel_wdata = wdata[i*32 +: 32];
          sel_be    = be[i*4 +: 4];
        end
      end
    end
  end

  assign aligned_addr = sel_addr & ~32'h3;

  dmem_be_merge u_merge (
    .old_word (mem_rdata),
    .new_word (sel_wdata),
    .be       (sel_be),
    .merged   (merged)
  );

  always_comb begin
    state_nxt = state;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    load_go   = 1'b0;
    rmw_go    = 1'b0;
    case (state)
      IDLE: begin
        if (any_gnt) begin
          if (!sel_we) begin
            MemRead  = 1'b1;
            mem_addr = aligned_addr;
            load_go  = 1'b1;
          end else if (sel_be == BE_FULL) begin
            MemWrite  = 1'b1;
            mem_addr  = aligned_addr;
            mem_wdata = sel_wdata;
          end else if (sel_be != '0) begin
            MemRead   = 1'b1;
            mem_addr  = aligned_addr;
            rmw_go    = 1'b1;
            state_nxt = RMW_WR;
          end
        end
      end
      RMW_WR: begin
        MemWrite  = 1'b1;
        mem_addr  = cap_addr;
        mem_wdata = cap_data;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last_gnt <= IW'(NPORTS - 1);
      rvalid   <= '0;
      rdata    <= '0;
      cap_addr <= '0;
      cap_data <= '0;
    end else begin
      state  <= state_nxt;
      rvalid <= load_go ? gnt : '0;
      if (any_gnt) last_gnt <= sel;
      if (load_go) rdata <= mem_rdata;
      if (rmw_go) begin
        cap_addr <= aligned_addr;
        cap_data <= merged;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: round-robin instance on a word memory,
// fixed-priority instance sharing the same requester stimulus.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req, we;
  logic [63:0] addr, wdata;
  logic [7:0]  be;

  logic [1:0]  gnt, rvalid, gnt_fp, rvalid_fp;
  logic [31:0] rdata, rdata_fp;
  logic        mem_read, mem_write, mem_read_fp, mem_write_fp;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] mem_addr_fp, mem_wdata_fp;
  logic [31:0] fp_rdata = 32'h5A5A5A5A;

  logic [31:0] mem [0:63];
  logic        mem_load;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.NPORTS(2), .RR_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .MemRead(mem_read), .MemWrite(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  dmem_arbiter #(.NPORTS(2), .RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
    .gnt(gnt_fp), .rvalid(rvalid_fp), .rdata(rdata_fp), .MemRead(mem_read_fp),
    .MemWrite(mem_write_fp), .mem_addr(mem_addr_fp), .mem_wdata(mem_wdata_fp),
    .mem_rdata(fp_rdata)
  );

  assign mem_rdata = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[3] <= 32'h12345678;
      mem[4] <= 32'hCAFEF00D;
    end else if (mem_write) begin
      mem[mem_addr[7:2]] <= mem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int p, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    req[p]            = r;
    we[p]             = w;
    addr[p*32 +: 32]  = a;
    wdata[p*32 +: 32] = d;
    be[p*4 +: 4]      = b;
  endtask

  task automatic idle_all();
    req = '0; we = '0; addr = '0; wdata = '0; be = '0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #3;
      chk("gnt_onehot0",     {31'b0, $onehot0(gnt)}, 32'd1);
      chk("gnt_fp_onehot0",  {31'b0, $onehot0(gnt_fp)}, 32'd1);
      chk("rvalid_onehot0",  {31'b0, $onehot0(rvalid)}, 32'd1);
      chk("rd_wr_exclusive", {31'b0, mem_read & mem_write}, 32'd0);
      chk("fp_rd_wr_excl",   {31'b0, mem_read_fp & mem_write_fp}, 32'd0);
    end
  end

  initial begin
    idle_all();
    mem_load = 1'b1;
    rst_n    = 1'b0;
    drive(0, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0);
    #2;
    chk("rst_gnt",       gnt, 0);
    chk("rst_gnt_fp",    gnt_fp, 0);
    chk("rst_rvalid",    rvalid, 0);
    chk("rst_rdata",     rdata, 0);
    chk("rst_memread",   mem_read, 0);
    chk("rst_memwrite",  mem_write, 0);
    chk("rst_mem_addr",  mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_fp_wdata",  mem_wdata_fp, 0);
    @(negedge clk);
    @(negedge clk);
    mem_load = 1'b0;
    rst_n    = 1'b1;
    idle_all();

    // Full store then load of 0x08
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 32'h8, 32'hDEADBEEF, 4'hF);
    #1;
    chk("sw_gnt", gnt, 2'b01);
    chk("sw_memwrite", mem_write, 1);
    chk("sw_memread", mem_read, 0);
    chk("sw_mem_addr", mem_addr, 32'h8);
    chk("sw_mem_wdata", mem_wdata, 32'hDEADBEEF);
    @(negedge clk);
    chk("sw_no_rvalid", rvalid, 0);
    drive(0, 1'b1, 1'b0, 32'hB, 32'h0, 4'h0);
    #1;
    chk("lw_gnt", gnt, 2'b01);
    chk("lw_memread", mem_read, 1);
    chk("lw_mem_addr_aligned", mem_addr, 32'h8);
    @(negedge clk);
    chk("lw_rvalid", rvalid, 2'b01);
    chk("lw_rdata", rdata, 32'hDEADBEEF);
    idle_all();
    #1;
    chk("idle_gnt", gnt, 0);
    chk("idle_memread", mem_read, 0);
    chk("idle_memwrite", mem_write, 0);

    // Partial store from port 1 into 0x0C
    @(negedge clk);
    chk("rvalid_one_cycle", rvalid, 0);
    drive(1, 1'b1, 1'b1, 32'hC, 32'h0000AB00, 4'b0010);
    #1;
    chk("sb_gnt", gnt, 2'b10);
    chk("sb_memread", mem_read, 1);
    chk("sb_memwrite", mem_write, 0);
    chk("sb_mem_addr", mem_addr, 32'hC);
    @(negedge clk);
    idle_all();
    drive(0, 1'b1, 1'b0, 32'hC, 32'h0, 4'h0);
    #1;
    chk("rmw_no_gnt", gnt, 0);
    chk("rmw_memwrite", mem_write, 1);
    chk("rmw_memread", mem_read, 0);
    chk("rmw_mem_addr", mem_addr, 32'hC);
    chk("rmw_mem_wdata", mem_wdata, 32'h1234AB78);
    @(negedge clk);
    #1;
    chk("post_rmw_gnt", gnt, 2'b01);
    chk("post_rmw_addr", mem_addr, 32'hC);
    @(negedge clk);
    chk("rmw_readback_rvalid", rvalid, 2'b01);
    chk("rmw_readback_rdata", rdata, 32'h1234AB78);
    drive(0, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0);
    #1;
    chk("b2b_gnt", gnt, 2'b01);
    chk("b2b_rvalid", rvalid, 2'b01);
    @(negedge clk);
    chk("b2b_rvalid2", rvalid, 2'b01);
    chk("b2b_rdata2", rdata, 32'hDEADBEEF);
    idle_all();

    // Contention: both ports load every cycle
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0);
    drive(1, 1'b1, 1'b0, 32'hC, 32'h0, 4'h0);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      chk("rr_gnt", gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
      chk("fp_gnt", gnt_fp, 2'b01);
      if (i > 0) begin
        chk("rr_rvalid", rvalid, ((i - 1) % 2 == 0) ? 2'b01 : 2'b10);
        chk("rr_rdata", rdata, ((i - 1) % 2 == 0) ? 32'hDEADBEEF : 32'h1234AB78);
      end
      if (i == 1) chk("fp_rdata", rdata_fp, 32'h5A5A5A5A);
    end
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    chk("fp_gnt_port1", gnt_fp, 2'b10);
    chk("rr_gnt_port1", gnt, 2'b10);

    // Store with no byte enables
    @(negedge clk);
    idle_all();
    drive(0, 1'b1, 1'b1, 32'h20, 32'h11111111, 4'h0);
    #1;
    chk("be0_gnt", gnt, 2'b01);
    chk("be0_memwrite", mem_write, 0);
    chk("be0_memread", mem_read, 0);

    // Reset during RMW_WR of a partial store to 0x10
    @(negedge clk);
    chk("be0_no_rvalid", rvalid, 0);
    drive(0, 1'b1, 1'b1, 32'h10, 32'h000000AA, 4'b0001);
    #1;
    chk("rst_rmw_gnt", gnt, 2'b01);
    chk("rst_rmw_memread", mem_read, 1);
    chk("rst_rmw_addr", mem_addr, 32'h10);
    @(negedge clk);
    idle_all();
    #1;
    chk("rst_rmw_active", mem_write, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_rmw_abandon", mem_write, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_memwrite", mem_write, 0);
    @(negedge clk);
    chk("post_rst_memwrite2", mem_write, 0);
    drive(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    #1;
    chk("post_rst_gnt", gnt, 2'b01);
    chk("post_rst_memread", mem_read, 1);
    @(negedge clk);
    chk("post_rst_rvalid", rvalid, 2'b01);
    chk("mem10_unchanged", rdata, 32'hCAFEF00D);
    idle_all();

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
